// File: rtl/serial_digit_rx.sv
// Serial nibble receiver feeding a 4-digit shift register for the scan/display path.
// Frame: start(0), 4 data bits LSB first, optional even parity bit, stop(1).
// Each bit is OVS ticks of clk_out; bits are sampled at mid-bit.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | line idle, waiting for synchronized rxd low
// S_START     | confirming start bit at mid-bit (glitch filter)
// S_DATA      | sampling 4 data bits, idx selects shreg bit
// S_PARITY    | sampling parity bit (only when PARITY_EN = 1)
// S_STOP      | sampling stop bit, commit or flag an error
// S_WAIT_HIGH | bad stop bit, waiting for the line to return high
module serial_digit_rx #(
    parameter int OVS       = 4,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic       clk_out,
    input  logic       rst_n,
    input  logic       rxd,
    input  logic       dir,
    input  logic       clr,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic [3:0] dig3,
    output logic       valid,
    output logic       par_err,
    output logic       frm_err,
    output logic       busy
);

    localparam int CW = $clog2(OVS);
    localparam logic [CW-1:0] CNT_HALF = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0]      shreg_q, shreg_d;
    logic            par_q, par_d;
    logic            valid_q, valid_d;
    logic            par_err_q, par_err_d;
    logic            frm_err_q, frm_err_d;
    logic [3:0]      dig_q [4];
    logic [3:0]      dig_d [4];
    logic            sync1_q, sync2_q;
    logic            rx;
    logic            par_ok;
    logic            commit;

    assign rx     = sync2_q;
    assign par_ok = PARITY_EN ? ~(^{shreg_q, par_q}) : 1'b1;

    // Two-flop synchronizer for the asynchronous serial line; idles high.
    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
        end
    end

    // State, counters, shift register, status pulses and digit registers.
    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            for (int i = 0; i < 4; i++) dig_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            valid_q   <= valid_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            for (int i = 0; i < 4; i++) dig_q[i] <= dig_d[i];
        end
    end

    // Next-state logic, frame decoding and digit shifting.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        valid_d   = 1'b0;
        par_err_d = 1'b0;
        frm_err_d = 1'b0;
        commit    = 1'b0;
        dig_d     = dig_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rx ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = rx;
                    idx_d          = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = PARITY_EN ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    par_d   = rx;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (!rx) begin
                        frm_err_d = 1'b1;
                        state_d   = S_WAIT_HIGH;
                    end else if (par_ok) begin
                        valid_d = 1'b1;
                        commit  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        par_err_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
            S_WAIT_HIGH: begin
                cnt_d = '0;
                if (rx) state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        // Clear overrides a coincident commit; valid still pulses.
        if (clr) begin
            for (int i = 0; i < 4; i++) dig_d[i] = '0;
        end else if (commit) begin
            if (dir) begin
                dig_d[3] = dig_q[2];
                dig_d[2] = dig_q[1];
                dig_d[1] = dig_q[0];
                dig_d[0] = shreg_q;
            end else begin
                dig_d[0] = dig_q[1];
                dig_d[1] = dig_q[2];
                dig_d[2] = dig_q[3];
                dig_d[3] = shreg_q;
            end
        end
    end

    assign dig0    = dig_q[0];
    assign dig1    = dig_q[1];
    assign dig2    = dig_q[2];
    assign dig3    = dig_q[3];
    assign valid   = valid_q;
    assign par_err = par_err_q;
    assign frm_err = frm_err_q;
    assign busy    = (state_q != S_IDLE);

endmodule
